// File: rtl/dmem_resp.sv
// ============================================================================
// dmem_resp : dmem responder - word RAM, byte TX FIFO, cycle counter, fault latch
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_resp #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int c_ram_aw  = $clog2(RAM_WORDS);
  localparam int c_fifo_aw = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w   = c_fifo_aw + 1;

  localparam logic [31:0]        c_addr_tx   = 32'h8000_0000;
  localparam logic [31:0]        c_addr_st   = 32'h8000_0004;
  localparam logic [31:0]        c_addr_cyc  = 32'h8000_0008;
  localparam logic [31:0]        c_addr_fa   = 32'h8000_000C;
  localparam logic [c_cnt_w-1:0] c_full_cnt  = c_cnt_w'(FIFO_DEPTH);

  logic [31:0]          ram_q  [RAM_WORDS];
  logic [7:0]           fifo_q [FIFO_DEPTH];
  logic [c_fifo_aw-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d, fault_q, fault_d;
  logic [31:0]          faddr_q, faddr_d, cyc_q, cyc_d;

  logic                 w_misaligned, w_is_ram, w_is_tx, w_is_st, w_is_cyc, w_is_fa;
  logic                 w_fault, w_wr, w_full, w_empty, w_push, w_pop, w_push_ok;
  logic [c_ram_aw-1:0]  w_ram_idx;

  assign w_misaligned = |dmem_addr[1:0];
  assign w_is_ram     = (dmem_addr[31:c_ram_aw+2] == '0);
  assign w_is_tx      = (dmem_addr == c_addr_tx);
  assign w_is_st      = (dmem_addr == c_addr_st);
  assign w_is_cyc     = (dmem_addr == c_addr_cyc);
  assign w_is_fa      = (dmem_addr == c_addr_fa);
  assign w_ram_idx    = dmem_addr[c_ram_aw+1:2];

  assign w_fault = (dmem_read || dmem_write) &&
                   (w_misaligned || !(w_is_ram || w_is_tx || w_is_st || w_is_cyc || w_is_fa));
  // reset_n gates stores so the un-reset RAM and FIFO storage stay untouched in reset
  assign w_wr    = reset_n && dmem_write && !w_fault;

  assign w_full    = (cnt_q == c_full_cnt);
  assign w_empty   = (cnt_q == '0);
  assign w_pop     = !w_empty && tx_ready;
  assign w_push    = w_wr && w_is_tx;
  assign w_push_ok = w_push && (!w_full || w_pop);

  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign fault    = fault_q;

  always_comb begin
    dmem_rdata = '0;
    if (reset_n && !w_misaligned) begin
      if (w_is_ram)      dmem_rdata = ram_q[w_ram_idx];
      else if (w_is_st)  dmem_rdata = {16'h0, 8'(cnt_q), 5'h0, ovf_q, w_full, w_empty};
      else if (w_is_cyc) dmem_rdata = cyc_q;
      else if (w_is_fa)  dmem_rdata = faddr_q;
    end
  end

  always_comb begin
    cnt_d    = cnt_q + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop);
    rd_ptr_d = rd_ptr_q + c_fifo_aw'(w_pop);
    wr_ptr_d = wr_ptr_q + c_fifo_aw'(w_push_ok);

    // a dropped push outranks a same-cycle overflow clear
    ovf_d = ovf_q;
    if (w_wr && w_is_st && dmem_wdata[2]) ovf_d = 1'b0;
    if (w_push && w_full && !w_pop)       ovf_d = 1'b1;

    cyc_d = (w_wr && w_is_cyc) ? dmem_wdata : cyc_q + 32'd1;

    fault_d = fault_q;
    faddr_d = faddr_q;
    if (w_fault) begin
      fault_d = 1'b1;
      faddr_d = dmem_addr;
    end else if (w_wr && w_is_fa && dmem_wdata[0]) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fault_q  <= 1'b0;
      faddr_q  <= '0;
      cyc_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fault_q  <= fault_d;
      faddr_q  <= faddr_d;
      cyc_q    <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && w_is_ram) ram_q[w_ram_idx] <= dmem_wdata;
    if (w_push_ok)        fifo_q[wr_ptr_q] <= dmem_wdata[7:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// ============================================================================
// tb_dmem_resp : directed vector table, async-reset sequence and random run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_resp;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_TX = 32'h8000_0000;
  localparam logic [31:0] A_ST = 32'h8000_0004;
  localparam logic [31:0] A_CY = 32'h8000_0008;
  localparam logic [31:0] A_FA = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dmem_read = 1'b0, dmem_write = 1'b0, tx_ready = 1'b0;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        tx_valid, fault;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  dmem_resp #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .fault(fault)
  );

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic        exp_f;
  } vec_t;
  vec_t tbl[$];

  // reference model: plain queue for the FIFO, small RAM window with known flags
  logic [7:0]  m_q[$];
  logic        m_ovf, m_fault;
  logic [31:0] m_faddr, m_cyc;
  logic [31:0] m_ram [16];
  logic        m_known [16];

  function automatic void add(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic rdy, input logic c,
                              input logic [31:0] er, input logic ev, input logic [7:0] ed,
                              input logic ef);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.rdy = rdy;
    v.chk_rd = c; v.exp_rd = er; v.exp_v = ev; v.exp_d = ed; v.exp_f = ef;
    tbl.push_back(v);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) ||
           !((a < 32'(RAM_WORDS * 4)) || a == A_TX || a == A_ST || a == A_CY || a == A_FA);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    dmem_read = rd; dmem_write = wr; dmem_addr = a; dmem_wdata = wd; tx_ready = rdy;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_fault = 1'b0; m_faddr = '0; m_cyc = '0;
  endtask

  task automatic model_rdata(output logic [31:0] v, output logic known);
    known = 1'b1;
    v = '0;
    if (bad_addr(dmem_addr)) v = '0;
    else if (dmem_addr < 32'(RAM_WORDS * 4)) begin
      if (dmem_addr < 32'h40 && m_known[dmem_addr[5:2]]) v = m_ram[dmem_addr[5:2]];
      else known = 1'b0;
    end
    else if (dmem_addr == A_ST)
      v = {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == FIFO_DEPTH, m_q.size() == 0};
    else if (dmem_addr == A_CY) v = m_cyc;
    else if (dmem_addr == A_FA) v = m_faddr;
  endtask

  task automatic model_step();
    logic f, wr_ok, pop, full_before;
    f = (dmem_read || dmem_write) && bad_addr(dmem_addr);
    wr_ok = dmem_write && !f;
    pop = (m_q.size() != 0) && tx_ready;
    full_before = (m_q.size() == FIFO_DEPTH);
    if (wr_ok && dmem_addr < 32'h40) begin
      m_ram[dmem_addr[5:2]] = dmem_wdata;
      m_known[dmem_addr[5:2]] = 1'b1;
    end
    if (wr_ok && dmem_addr == A_CY) m_cyc = dmem_wdata;
    else m_cyc = m_cyc + 32'd1;
    if (pop) void'(m_q.pop_front());
    if (wr_ok && dmem_addr == A_ST && dmem_wdata[2]) m_ovf = 1'b0;
    if (wr_ok && dmem_addr == A_TX) begin
      if (!full_before || pop) m_q.push_back(dmem_wdata[7:0]);
      else m_ovf = 1'b1;
    end
    if (f) begin
      m_fault = 1'b1;
      m_faddr = dmem_addr;
    end else if (wr_ok && dmem_addr == A_FA && dmem_wdata[0]) begin
      m_fault = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] v;
    logic        known;
    model_rdata(v, known);
    if (known) chk({tag, " rdata"}, dmem_rdata, v);
    chk({tag, " tx_valid"}, 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, " tx_data"}, 32'(tx_data), 32'(m_q[0]));
    chk({tag, " fault"}, 32'(fault), 32'(m_fault));
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_known[i] = 1'b0;
      m_ram[i] = '0;
    end
    model_reset();

    // directed vectors; expectations describe outputs before the row's clock edge
    add(1, 0, A_ST, 0, 0, 1, 32'h1, 0, 0, 0);
    add(1, 0, A_CY, 0, 0, 1, 32'h1, 0, 0, 0);
    add(0, 1, 32'h0, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h10, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
    add(1, 1, 32'h10, 32'hCAFE_BABE, 0, 1, 32'h1111_1111, 0, 0, 0);
    add(1, 0, 32'h10, 0, 0, 1, 32'hCAFE_BABE, 0, 0, 0);
    add(0, 1, 32'h14, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    add(1, 0, 32'h14, 0, 0, 1, 32'h1234_5678, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, A_TX, 32'(32'h41 + i), 0, 1, 0, i != 0, 8'h41, 0);
    add(1, 0, A_ST, 0, 0, 1, 32'h0000_0802, 1, 8'h41, 0);
    add(0, 1, A_TX, 32'h49, 0, 1, 0, 1, 8'h41, 0);
    add(1, 0, A_ST, 0, 0, 1, 32'h0000_0806, 1, 8'h41, 0);
    for (int i = 0; i < 8; i++) add(0, 0, A_TX, 0, 1, 1, 0, 1, 8'(32'h41 + i), 0);
    add(0, 1, A_ST, 32'h4, 0, 1, 32'h5, 0, 0, 0);
    add(1, 0, A_ST, 0, 0, 1, 32'h1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, A_TX, 32'(32'h61 + i), 0, 1, 0, i != 0, 8'h61, 0);
    add(0, 1, A_TX, 32'h55, 1, 1, 0, 1, 8'h61, 0);
    add(1, 0, A_ST, 0, 0, 1, 32'h0000_0802, 1, 8'h62, 0);
    for (int i = 0; i < 8; i++) add(0, 0, A_TX, 0, 1, 1, 0, 1, (i < 7) ? 8'(32'h62 + i) : 8'h55, 0);
    add(0, 1, A_CY, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
    add(1, 0, A_CY, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    add(1, 0, A_CY, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    add(1, 0, A_CY, 0, 0, 1, 32'h0000_0000, 0, 0, 0);
    add(1, 0, 32'h2, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, A_FA, 0, 0, 1, 32'h2, 0, 0, 1);
    add(0, 1, 32'h4000_0000, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 1);
    add(1, 0, A_FA, 0, 0, 1, 32'h4000_0000, 0, 0, 1);
    add(1, 0, 32'h0, 0, 0, 1, 32'hA5A5_A5A5, 0, 0, 1);
    add(0, 1, A_FA, 32'h1, 0, 1, 32'h4000_0000, 0, 0, 1);
    add(1, 0, A_ST, 0, 0, 1, 32'h1, 0, 0, 0);

    drive(1, 0, A_CY, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset rdata", dmem_rdata, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
      @(negedge clk);
      if (tbl[i].chk_rd) chk($sformatf("row%0d rdata", i), dmem_rdata, tbl[i].exp_rd);
      chk($sformatf("row%0d tx_valid", i), 32'(tx_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("row%0d tx_data", i), 32'(tx_data), 32'(tbl[i].exp_d));
      chk($sformatf("row%0d fault", i), 32'(fault), 32'(tbl[i].exp_f));
      finish_cycle();
    end

    // asynchronous reset in the middle of a drain
    drive(1, 0, 32'h2, 0, 0);
    @(negedge clk); check_model("pre-rst fault"); finish_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, A_TX, 32'(32'hA0 + i), 0);
      @(negedge clk); check_model("pre-rst push"); finish_cycle();
    end
    drive(1, 0, A_CY, 0, 1);
    @(negedge clk); check_model("pre-rst drain");
    #1 reset_n = 1'b0;
    #1;
    chk("async tx_valid", 32'(tx_valid), 32'd0);
    chk("async tx_data", 32'(tx_data), 32'd0);
    chk("async fault", 32'(fault), 32'd0);
    chk("async rdata", dmem_rdata, 32'd0);
    model_reset();
    drive(0, 1, 32'h10, 32'h7777_7777, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1, 0, A_CY, 0, 0);
    @(negedge clk); chk("release cycle", dmem_rdata, 32'd0); finish_cycle();
    drive(1, 0, A_ST, 0, 0);
    @(negedge clk); chk("release status", dmem_rdata, 32'h1); finish_cycle();
    drive(1, 0, 32'h10, 0, 0);
    @(negedge clk); chk("release ram", dmem_rdata, 32'hCAFE_BABE); finish_cycle();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned k;
      logic [31:0] a;
      k = $urandom_range(0, 13);
      case (k)
        0, 1, 2, 3: a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        4, 5, 6:    a = A_TX;
        7:          a = A_ST;
        8:          a = A_CY;
        9:          a = A_FA;
        10:         a = {26'h0, 4'($urandom), 2'($urandom_range(1, 3))};
        11:         a = 32'h4000_0000;
        12:         a = 32'h8000_0010;
        default:    a = 32'(RAM_WORDS * 4);
      endcase
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 2) == 0));
      @(negedge clk);
      check_model("rand");
      finish_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder at the far end of the CPU's dmem interface. Serves the single-cycle core's loads combinationally and commits stores on the clock edge. Backs a word RAM plus a small MMIO block: a byte TX FIFO with a valid/ready drain port, a free-running cycle counter, and a sticky access-fault latch. Sits beside the core in the top level, driven directly by `dmem_read`, `dmem_write`, `dmem_addr` and `dmem_wdata`.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: TX FIFO depth in bytes; power of two, 2..128.
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `dmem_read` in 1: load request, this cycle.
- `dmem_write` in 1: store request, this cycle.
- `dmem_addr` in 32: byte address.
- `dmem_wdata` in 32: store data.
- `dmem_rdata` out 32: load data, combinational from address.
- `tx_valid` out 1: FIFO head byte available.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: consumer accepts head at posedge when `tx_valid`.
- `fault` out 1: sticky access fault.

## Operation
- Address map; word access only:
  - RAM at `0x0000_0000` .. `RAM_WORDS*4-1`, indexed by `addr[log2(RAM_WORDS)+1:2]`.
  - TXDATA at `0x8000_0000`.
    - Write pushes `wdata[7:0]`.
    - Read returns 0.
  - STATUS at `0x8000_0004`.
    - Read returns `{16'h0, count[7:0], 5'h0, overflow, full, empty}`.
    - Write with `wdata[2]=1` clears overflow.
  - CYCLE at `0x8000_0008`.
    - Read returns the counter.
    - Write loads it.
  - FAULT_ADDR at `0x8000_000C`.
    - Read returns the last faulting address.
    - Write with `wdata[0]=1` clears `fault`.
- Fault is any access (read or write) that is misaligned (`addr[1:0]!=0`) or to an unmapped address.
  - Sets `fault` and captures `dmem_addr` into FAULT_ADDR.
  - A faulting write has no side effect.
  - A faulting read returns 0.
  - A new fault overwrites FAULT_ADDR.
- Neither read nor write asserted: `dmem_rdata` still decodes the address, with no fault and no side effects.
- Read and write asserted together: write is performed; `dmem_rdata` shows the pre-write value.
- RAM contents are not reset.
- FIFO push/pop rules:
  - Push when not full: byte enqueued.
  - Push when full and no same-cycle pop: byte dropped, `overflow` set (sticky).
  - Push when full with a same-cycle pop: push accepted, count unchanged.
  - Push when empty: no bypass; `tx_valid` rises the following cycle.
- Cycle counter:
  - Increments by 1 every cycle, wrapping `0xFFFF_FFFF -> 0`.
  - A CYCLE write loads `wdata` at that edge; increments resume the next edge.
- Overflow clear and a same-cycle overflowing push: the set wins.
- FAULT_ADDR write with `wdata[0]=1` and a same-cycle fault: the fault wins.

## Timing
- Loads: zero latency. `dmem_rdata` is combinational from `dmem_addr` and the registered state.
- Stores: committed at the posedge. A read of the same location in the next cycle returns the new value.
- STATUS and CYCLE reads return the registered value before that edge's update.
- Handshake: a byte transfers at a posedge with `tx_valid && tx_ready`. `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.
- Reset (`reset_n` low, asynchronous), any time including mid-transfer:
  - FIFO empty, `tx_valid=0`, `tx_data=0`.
  - Overflow 0, `fault=0`, FAULT_ADDR 0, counter 0.
  - While held low: `dmem_rdata=0` and stores are ignored.
- Release: the first posedge with `reset_n` high increments the counter to 1 and accepts stores.

## Test plan
- Store RAM: `0x10 <- 0xCAFEBABE`, `0x14 <- 0x12345678`, then load both. Expect those values in the cycle after each store. Loading `0x10` in the store's own cycle returns the old value.
- TX FIFO:
  - With `tx_ready=0`, push 0x41..0x48: STATUS=`0x0000_0802`.
  - A ninth push: STATUS bit2=1, byte dropped.
  - Raise `tx_ready`: drains 0x41..0x48 in order over 8 cycles, then `tx_valid=0`.
- Full with simultaneous push+pop: push 0x55 while full with `tx_ready=1`. Expect accepted, count stays 8, overflow stays 0, 0x55 emerges last.
- Counter: write CYCLE `0xFFFF_FFFE`. Reads on the next three cycles return `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0x0000_0000`.
- Faults:
  - Load `0x0000_0002`: `fault=1`, FAULT_ADDR=`0x0000_0002`, rdata 0.
  - Store to `0x4000_0000`: no RAM change, FAULT_ADDR=`0x4000_0000`.
  - Write FAULT_ADDR with `1`: `fault=0`.
- Async reset mid-drain: assert `reset_n=0` between edges with 4 bytes queued. `tx_valid`, `fault` and the counter clear immediately without a clock edge. After release, STATUS=`0x0000_0001`.
